axi_isolate_drain: RTL and testbench

- Graceful AXI isolation stage with one clock domain. It sits between an upstream AXI master port (s_) and a downstream slave port (m_), for example in front of a dual-clock slice or a power-gated cluster port.
- An isolation request does not cut the channels mid-transaction. The block first stops new AW/AR, then drains all outstanding bursts, then reports isolated.
- While isolated, TERMINATE mode answers new requests with DECERR so upstream masters never hang.
- Only handshake, ID, resp and last signals pass through this block. Address, W payload and R data are wired around it.

---
 rtl/axi_isolate_drain_if.sv | 16 +
 rtl/axi_isolate_drain.sv | 147 ++++++++++++++
 tb/tb_axi_isolate_drain.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_isolate_drain_if.sv
// axi_isolate_drain_if: AXI handshake/ID/resp/last subset carried through the isolation stage
interface axi_isolate_drain_if #(parameter int AXI_ID_WIDTH = 10);
  logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [AXI_ID_WIDTH-1:0] aw_id, b_id, ar_id, r_id;
  logic [7:0] aw_len, ar_len;
  logic [1:0] b_resp, r_resp;
  modport master (
    output aw_valid, w_valid, ar_valid, b_ready, r_ready,
    input aw_ready, w_ready, ar_ready, b_valid, b_id, b_resp, r_valid, r_id, r_resp, r_last
  );
  modport slave (
    input aw_valid, aw_id, aw_len, w_valid, w_last, ar_valid, ar_id, ar_len, b_ready, r_ready,
    output aw_ready, w_ready, ar_ready, b_valid, b_id, b_resp, r_valid, r_id, r_resp, r_last
  );
endinterface

// File: rtl/axi_isolate_drain.sv
// axi_isolate_drain: drains outstanding AXI bursts before isolating; optional DECERR termination.
// Optional stats ports enabled by AXI_ISOLATE_STATS_EN.
module axi_isolate_drain #(
  parameter int AXI_ID_WIDTH = 10,
  parameter int MAX_TXNS = 8,
  parameter int TERMINATE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic isolate_i,
  output logic isolated_o,
  axi_isolate_drain_if.slave s,
  axi_isolate_drain_if.master m
`ifdef AXI_ISOLATE_STATS_EN
  ,
  output logic [15:0] term_cnt_o,
  output logic [15:0] drain_cycles_o
`endif
);
  localparam int CW = $clog2(MAX_TXNS + 1);
  typedef enum logic [1:0] {RUN, DRAIN, ISO, ERR} state_t;
  state_t state, state_n;
  logic [CW-1:0] wr_out, rd_out, w_owed;
  logic [AXI_ID_WIDTH-1:0] cap_id;
  logic [7:0] cap_len, beat;
  logic cap_wr, w_done, err_done, take_aw, take_ar, err_last;
  logic aw_hs, b_hs, ar_hs, r_hs, w_hs, aw_gate, ar_gate, owed, idle, pass, unused;
  assign aw_hs = m.aw_valid & m.aw_ready;
  assign b_hs = m.b_valid & m.b_ready;
  assign ar_hs = m.ar_valid & m.ar_ready;
  assign r_hs = m.r_valid & m.r_ready & m.r_last;
  assign w_hs = m.w_valid & m.w_ready & s.w_last;
  assign aw_gate = isolate_i | (wr_out == CW'(MAX_TXNS));
  assign ar_gate = isolate_i | (rd_out == CW'(MAX_TXNS));
  assign owed = w_owed != '0;
  assign idle = (wr_out == '0) & (rd_out == '0) & ~owed;
  assign pass = (state == RUN) | (state == DRAIN);
  assign err_last = beat == cap_len;
  assign unused = ^s.aw_len;
  always_comb begin
    state_n = state;
    take_aw = 1'b0;
    take_ar = 1'b0;
    err_done = 1'b0;
    m.aw_valid = 1'b0;
    m.ar_valid = 1'b0;
    m.w_valid = 1'b0;
    s.aw_ready = 1'b0;
    s.ar_ready = 1'b0;
    s.w_ready = 1'b0;
    s.b_valid = pass & m.b_valid;
    m.b_ready = pass ? s.b_ready : 1'b1;
    s.b_id = m.b_id;
    s.b_resp = m.b_resp;
    s.r_valid = pass & m.r_valid;
    m.r_ready = pass ? s.r_ready : 1'b1;
    s.r_id = m.r_id;
    s.r_resp = m.r_resp;
    s.r_last = m.r_last;
    case (state)
      RUN: begin
        m.aw_valid = s.aw_valid & ~aw_gate;
        s.aw_ready = m.aw_ready & ~aw_gate;
        m.ar_valid = s.ar_valid & ~ar_gate;
        s.ar_ready = m.ar_ready & ~ar_gate;
        m.w_valid = s.w_valid;
        s.w_ready = m.w_ready;
        state_n = isolate_i ? DRAIN : RUN;
      end
      DRAIN: begin
        m.w_valid = s.w_valid & owed;
        s.w_ready = m.w_ready & owed;
        state_n = !isolate_i ? RUN : idle ? ISO : DRAIN;
      end
      ISO: begin
        // requests are only accepted while still isolating, so a terminated burst is never orphaned
        s.aw_ready = (TERMINATE != 0) & isolate_i;
        s.ar_ready = (TERMINATE != 0) & isolate_i & ~s.aw_valid;
        s.w_ready = (TERMINATE != 0) & isolate_i;
        take_aw = s.aw_valid & s.aw_ready;
        take_ar = s.ar_valid & s.ar_ready;
        state_n = !isolate_i ? RUN : (take_aw | take_ar) ? ERR : ISO;
      end
      ERR: begin
        s.w_ready = cap_wr & ~w_done;
        s.b_valid = cap_wr & w_done;
        s.r_valid = ~cap_wr;
        s.b_id = cap_id;
        s.r_id = cap_id;
        s.b_resp = 2'b11;
        s.r_resp = 2'b11;
        s.r_last = err_last;
        err_done = cap_wr ? w_done & s.b_ready : s.r_ready & err_last;
        state_n = !err_done ? ERR : isolate_i ? ISO : RUN;
      end
    endcase
    if (rst_i) begin
      m.aw_valid = 1'b0;
      m.ar_valid = 1'b0;
      m.w_valid = 1'b0;
      s.b_valid = 1'b0;
      s.r_valid = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      isolated_o <= 1'b0;
      wr_out <= '0;
      rd_out <= '0;
      w_owed <= '0;
      cap_wr <= 1'b0;
      cap_id <= '0;
      cap_len <= '0;
      beat <= '0;
      w_done <= 1'b0;
    end else begin
      state <= state_n;
      isolated_o <= state_n == ISO;
      wr_out <= wr_out + CW'(aw_hs) - CW'(b_hs);
      rd_out <= rd_out + CW'(ar_hs) - CW'(r_hs);
      w_owed <= w_owed + CW'(aw_hs) - CW'(w_hs);
      if (take_aw | take_ar) begin
        cap_wr <= take_aw;
        cap_id <= take_aw ? s.aw_id : s.ar_id;
        cap_len <= take_aw ? 8'd0 : s.ar_len;
        beat <= '0;
        w_done <= take_aw & s.w_valid & s.w_last;
      end else if (state == ERR) begin
        if (s.w_valid & s.w_ready & s.w_last) w_done <= 1'b1;
        if (s.r_valid & s.r_ready) beat <= beat + 8'd1;
      end
    end
  end
`ifdef AXI_ISOLATE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      term_cnt_o <= '0;
      drain_cycles_o <= '0;
    end else begin
      if (take_aw | take_ar) term_cnt_o <= term_cnt_o + 16'd1;
      if (state == RUN && state_n == DRAIN) drain_cycles_o <= '0;
      else if (state == DRAIN && drain_cycles_o != '1) drain_cycles_o <= drain_cycles_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_isolate_drain.sv
// tb_axi_isolate_drain: directed checks of passthrough, drain, saturation, termination and reset.
module tb_axi_isolate_drain;
  logic clk = 1'b0, rst = 1'b1, isolate = 1'b0;
  logic isolated, isolated2;
  int n_vec = 0, n_err = 0;
  axi_isolate_drain_if #(.AXI_ID_WIDTH(10)) su (), mu (), su2 (), mu2 ();
  always #5 clk = ~clk;
  axi_isolate_drain #(.AXI_ID_WIDTH(10), .MAX_TXNS(8), .TERMINATE(1)) dut (
    .clk_i(clk), .rst_i(rst), .isolate_i(isolate), .isolated_o(isolated), .s(su), .m(mu)
`ifdef AXI_ISOLATE_STATS_EN
    , .term_cnt_o(), .drain_cycles_o()
`endif
  );
  axi_isolate_drain #(.AXI_ID_WIDTH(10), .MAX_TXNS(2), .TERMINATE(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .isolate_i(1'b0), .isolated_o(isolated2), .s(su2), .m(mu2)
`ifdef AXI_ISOLATE_STATS_EN
    , .term_cnt_o(), .drain_cycles_o()
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    {su.aw_valid, su.aw_id, su.aw_len, su.w_valid, su.w_last, su.ar_valid, su.ar_id, su.ar_len, su.b_ready, su.r_ready} = '0;
    {mu.aw_ready, mu.w_ready, mu.ar_ready, mu.b_valid, mu.b_id, mu.b_resp, mu.r_valid, mu.r_id, mu.r_resp, mu.r_last} = '0;
    {mu.aw_id, mu.aw_len, mu.w_last, mu.ar_id, mu.ar_len} = '0;
    {su2.aw_valid, su2.aw_id, su2.aw_len, su2.w_valid, su2.w_last, su2.ar_valid, su2.ar_id, su2.ar_len, su2.b_ready, su2.r_ready} = '0;
    {mu2.aw_ready, mu2.w_ready, mu2.ar_ready, mu2.b_valid, mu2.b_id, mu2.b_resp, mu2.r_valid, mu2.r_id, mu2.r_resp, mu2.r_last} = '0;
    {mu2.aw_id, mu2.aw_len, mu2.w_last, mu2.ar_id, mu2.ar_len} = '0;
    tick;
    su.aw_valid = 1; su.ar_valid = 1; mu.aw_ready = 1; mu.ar_ready = 1;
    #1 chk("rst_m_aw_valid", mu.aw_valid, 0);
    chk("rst_m_ar_valid", mu.ar_valid, 0);
    chk("rst_isolated", isolated, 0);
    tick;
    rst = 0; su.aw_valid = 0; su.ar_valid = 0;
    tick;
    // saturation on the MAX_TXNS=2 instance
    su2.aw_valid = 1; mu2.aw_ready = 1;
    #1 chk("sat_aw1", su2.aw_ready, 1);
    tick;
    chk("sat_aw2", su2.aw_ready, 1);
    tick;
    chk("sat_aw3_ready", su2.aw_ready, 0);
    chk("sat_aw3_valid", mu2.aw_valid, 0);
    mu2.b_valid = 1; su2.b_ready = 1;
    #1 chk("sat_aw3_during_b", su2.aw_ready, 0);
    tick;
    mu2.b_valid = 0;
    #1 chk("sat_aw3_after_b", su2.aw_ready, 1);
    chk("sat_aw3_m_valid", mu2.aw_valid, 1);
    tick;
    su2.aw_valid = 0;
    // passthrough
    su.aw_valid = 1; su.aw_id = 10'h55; su.aw_len = 3;
    #1 chk("pt_aw_valid", mu.aw_valid, 1);
    chk("pt_aw_ready", su.aw_ready, 1);
    tick;
    su.aw_valid = 0; su.w_valid = 1; mu.w_ready = 1;
    for (int i = 0; i < 4; i++) begin
      su.w_last = (i == 3);
      #1 chk("pt_w_valid", mu.w_valid, 1);
      tick;
    end
    su.w_valid = 0; su.w_last = 0;
    mu.b_valid = 1; mu.b_id = 10'h55; mu.b_resp = 2'b00; su.b_ready = 1;
    #1 chk("pt_b_valid", su.b_valid, 1);
    chk("pt_b_id", su.b_id, 10'h55);
    chk("pt_b_ready", mu.b_ready, 1);
    tick;
    mu.b_valid = 0;
    su.ar_valid = 1; su.ar_id = 10'h12; su.ar_len = 1;
    #1 chk("pt_ar_valid", mu.ar_valid, 1);
    tick;
    su.ar_valid = 0; mu.r_valid = 1; mu.r_id = 10'h12; mu.r_resp = 2'b00; mu.r_last = 0; su.r_ready = 1;
    #1 chk("pt_r_id", su.r_id, 10'h12);
    chk("pt_r_last0", su.r_last, 0);
    tick;
    mu.r_last = 1;
    #1 chk("pt_r_last1", su.r_last, 1);
    tick;
    mu.r_valid = 0; mu.r_last = 0; su.r_ready = 0;
    isolate = 1;
    tick;
    chk("pt_drain_not_iso", isolated, 0);
    tick;
    chk("pt_counters_zero_iso", isolated, 1);
    isolate = 0;
    tick;
    chk("pt_back_run", isolated, 0);
    // drain: 3 writes (one W still owed) and 2 reads outstanding
    su.aw_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      su.aw_id = 10'(i);
      #1 chk("dr_aw_pass", mu.aw_valid, 1);
      tick;
    end
    su.aw_valid = 0; su.ar_valid = 1;
    tick;
    tick;
    su.ar_valid = 0; su.w_valid = 1; su.w_last = 1;
    tick;
    tick;
    su.w_valid = 0;
    isolate = 1; su.aw_valid = 1; su.ar_valid = 1;
    #1 chk("dr_aw_gate_m", mu.aw_valid, 0);
    chk("dr_aw_gate_s", su.aw_ready, 0);
    chk("dr_ar_gate_m", mu.ar_valid, 0);
    chk("dr_ar_gate_s", su.ar_ready, 0);
    tick;
    chk("dr_aw_gate_drain", mu.aw_valid, 0);
    su.aw_valid = 0; su.ar_valid = 0; su.w_valid = 1;
    #1 chk("dr_w_owed_fwd", mu.w_valid, 1);
    tick;
    chk("dr_w_none_owed", mu.w_valid, 0);
    chk("dr_w_ready_none_owed", su.w_ready, 0);
    su.w_valid = 0; su.w_last = 0;
    mu.b_valid = 1; su.b_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      mu.b_id = 10'(i);
      tick;
    end
    mu.b_valid = 0;
    chk("dr_iso_wait_r", isolated, 0);
    mu.r_valid = 1; mu.r_last = 1; su.r_ready = 1;
    tick;
    tick;
    mu.r_valid = 0; mu.r_last = 0; su.r_ready = 0; su.b_ready = 0;
    #1 chk("dr_iso_not_early", isolated, 0);
    tick;
    chk("dr_iso_one_after", isolated, 1);
    // terminate write
    su.aw_valid = 1; su.aw_id = 10'h2A; su.aw_len = 3;
    #1 chk("tw_aw_ready", su.aw_ready, 1);
    chk("tw_m_aw_valid", mu.aw_valid, 0);
    tick;
    su.aw_valid = 0; su.w_valid = 1;
    for (int i = 0; i < 4; i++) begin
      su.w_last = (i == 3);
      #1 chk("tw_w_ready", su.w_ready, 1);
      chk("tw_m_w_valid", mu.w_valid, 0);
      chk("tw_b_early", su.b_valid, 0);
      tick;
    end
    su.w_valid = 0; su.w_last = 0;
    #1 chk("tw_b_valid", su.b_valid, 1);
    chk("tw_b_id", su.b_id, 10'h2A);
    chk("tw_b_resp", su.b_resp, 2'b11);
    tick;
    chk("tw_b_hold", su.b_valid, 1);
    su.b_ready = 1;
    tick;
    su.b_ready = 0;
    #1 chk("tw_b_done", su.b_valid, 0);
    chk("tw_back_iso", isolated, 1);
    // terminate read
    su.ar_valid = 1; su.ar_id = 10'h15; su.ar_len = 2;
    #1 chk("tr_ar_ready", su.ar_ready, 1);
    chk("tr_m_ar_valid", mu.ar_valid, 0);
    tick;
    su.ar_valid = 0;
    #1 chk("tr_r_valid", su.r_valid, 1);
    chk("tr_r_id", su.r_id, 10'h15);
    chk("tr_r_resp", su.r_resp, 2'b11);
    chk("tr_r_last_b0", su.r_last, 0);
    tick;
    chk("tr_r_hold", su.r_valid, 1);
    chk("tr_r_hold_last", su.r_last, 0);
    su.r_ready = 1;
    tick;
    chk("tr_r_last_b1", su.r_last, 0);
    su.r_ready = 0;
    tick;
    chk("tr_r_last_b1_hold", su.r_last, 0);
    su.r_ready = 1;
    tick;
    chk("tr_r_last_b2", su.r_last, 1);
    tick;
    su.r_ready = 0;
    #1 chk("tr_r_done", su.r_valid, 0);
    chk("tr_back_iso", isolated, 1);
    // abort drain
    isolate = 0;
    tick;
    chk("ab_run", isolated, 0);
    su.aw_valid = 1; su.aw_id = 10'h5;
    tick;
    su.aw_valid = 0; isolate = 1;
    tick;
    tick;
    chk("ab_draining", isolated, 0);
    isolate = 0;
    tick;
    chk("ab_not_iso", isolated, 0);
    mu.aw_ready = 0; su.aw_valid = 1;
    #1 chk("ab_run_aw_pass", mu.aw_valid, 1);
    su.aw_valid = 0; mu.aw_ready = 1; su.w_valid = 1; su.w_last = 1;
    tick;
    su.w_valid = 0; su.w_last = 0; mu.b_valid = 1; su.b_ready = 1;
    tick;
    mu.b_valid = 0; su.b_ready = 0;
    // reset in the middle of a terminated read
    isolate = 1;
    tick;
    tick;
    chk("rs_iso", isolated, 1);
    su.ar_valid = 1; su.ar_id = 10'h7; su.ar_len = 3;
    tick;
    su.ar_valid = 0;
    #1 chk("rs_err_r_valid", su.r_valid, 1);
    rst = 1;
    #1 chk("rs_during_r_valid", su.r_valid, 0);
    tick;
    rst = 0; isolate = 0;
    #1 chk("rs_r_valid", su.r_valid, 0);
    chk("rs_b_valid", su.b_valid, 0);
    chk("rs_isolated", isolated, 0);
    chk("rs_m_aw_valid", mu.aw_valid, 0);
    tick;
    chk("rs_run_r_valid", su.r_valid, 0);
    chk("rs_run_isolated", isolated, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
